// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch front-end stage that sits directly upstream of the instruction AXI read
// interface. It owns the fetch PC, drives the interface enable/PC, captures each
// returned (pc, instruction) pair into a small FIFO and presents the FIFO head
// to decode over a valid/ready handshake. A redirect flushes the FIFO and moves
// the fetch PC; responses still in flight for the old PC come back with a
// mismatching PC and are dropped.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a matching response arriving while the FIFO is empty is
//   presented to decode in the same cycle (zero-latency bypass).
//
// Parameters:
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   fetch_enable interface enable (registered)
//   fetch_pc     interface PC, next address to fetch (registered)
//   mem_pc       PC of the response currently offered by the interface
//   mem_inst     instruction of the response currently offered
//   mem_choke    low when the interface offers a valid response
//   redirect     branch/exception redirect request (highest priority)
//   redirect_pc  redirect target, passed through unaligned
//   out_valid    FIFO head valid to decode
//   out_ready    decode accepts the head
//   out_pc       head PC
//   out_inst     head instruction
//   queue_count  current FIFO occupancy
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   fetch_enable,
    output logic [31:0]            fetch_pc,
    input  logic [31:0]            mem_pc,
    input  logic [31:0]            mem_inst,
    input  logic                   mem_choke,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("inst_fetch_queue: DEPTH must be a power of 2 and at least 2");
    end

    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic [31:0]   fetch_pc_r;
    logic          fetch_enable_r;

    logic          accept_s;
    logic          match_s;
    logic          push_s;
    logic          pop_s;
    logic          head_valid_s;
    logic          bypass_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;

    // Response qualification, handshake and occupancy bookkeeping.
    always_comb begin
        // Capture is impossible while enable is low, even if choke pulses low.
        accept_s     = fetch_enable_r && !mem_choke;
        // A response whose PC differs from the current fetch PC is stale.
        match_s      = accept_s && (mem_pc == fetch_pc_r);
        push_s       = match_s && !redirect;
        head_valid_s = (count_r != {CW{1'b0}});
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s     = !head_valid_s && push_s;
`else
        bypass_s     = 1'b0;
`endif
        pop_s        = (head_valid_s || bypass_s) && out_ready && !redirect;
        // A bypassed response consumed by decode never enters storage.
        fifo_push_s  = push_s && !(bypass_s && out_ready);
        fifo_pop_s   = pop_s && head_valid_s;
        if (fifo_push_s && !fifo_pop_s) begin
            count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (!fifo_push_s && fifo_pop_s) begin
            count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Head presentation to decode; zero when nothing is offered.
    always_comb begin
        out_valid = head_valid_s || bypass_s;
        if (head_valid_s) begin
            out_pc   = pc_mem_r[rd_ptr_r];
            out_inst = inst_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            out_pc   = mem_pc;
            out_inst = mem_inst;
        end else begin
            out_pc   = 32'h0000_0000;
            out_inst = 32'h0000_0000;
        end
    end

    // Control state: fetch PC, enable, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r     <= RESET_PC;
            fetch_enable_r <= 1'b0;
            rd_ptr_r       <= {PW{1'b0}};
            wr_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
        end else if (redirect) begin
            // Flush; enable stays low for one cycle so the new PC settles.
            fetch_pc_r     <= redirect_pc;
            fetch_enable_r <= 1'b0;
            rd_ptr_r       <= {PW{1'b0}};
            wr_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
        end else begin
            // Registered from the next occupancy so a full FIFO never accepts.
            fetch_enable_r <= (count_next_s < DEPTH_C);
            count_r        <= count_next_s;
            if (fifo_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            pc_mem_r[wr_ptr_r]   <= mem_pc;
            inst_mem_r[wr_ptr_r] <= mem_inst;
        end
    end

    assign fetch_pc     = fetch_pc_r;
    assign fetch_enable = fetch_enable_r;
    assign queue_count  = count_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Self-checking bench for inst_fetch_queue. A stub interface issues one request
// at a time and answers with (pc, pc ^ 32'hFFFF_FFFF) after a random delay,
// holding the response until the DUT enable lets it be captured. A queue-based
// reference model predicts every output each cycle; directed phases pin the
// model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic [31:0] fetch_pc;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic        mem_choke;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  queue_count;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_enable (fetch_enable),
        .fetch_pc     (fetch_pc),
        .mem_pc       (mem_pc),
        .mem_inst     (mem_inst),
        .mem_choke    (mem_choke),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .queue_count  (queue_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of {pc, inst}, fetch PC, registered enable.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_en;
    logic [63:0] dlog[$];   // every entry delivered to decode, in order

    // Stub interface state.
    logic        st_busy;
    logic [31:0] st_pc;
    int          st_delay;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: stub drive, compare against model, advance model and stub.
    task automatic cycle();
        logic        acc;
        logic        mt;
        logic        byp;
        logic        take;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;

        if (!reset && !st_busy && (fetch_enable || ($urandom_range(0, 1) == 1))) begin
            st_busy  = 1'b1;
            st_pc    = fetch_pc;
            st_delay = $urandom_range(0, 2);
        end
        mem_choke = !(st_busy && (st_delay == 0));
        if (!mem_choke) begin
            mem_pc   = st_pc;
            mem_inst = st_pc ^ 32'hFFFF_FFFF;
        end else begin
            mem_pc   = ($urandom_range(0, 1) == 1) ? fetch_pc : $urandom;
            mem_inst = $urandom;
        end
        #1;

        acc  = m_en && !mem_choke;
        mt   = acc && (mem_pc == m_pc);
        byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp  = (m_q.size() == 0) && mt && !redirect;
`endif
        exp_v = (m_q.size() != 0) || byp;
        if (m_q.size() != 0) begin
            exp_pc   = m_q[0][63:32];
            exp_inst = m_q[0][31:0];
        end else if (byp) begin
            exp_pc   = mem_pc;
            exp_inst = mem_inst;
        end else begin
            exp_pc   = 32'h0000_0000;
            exp_inst = 32'h0000_0000;
        end

        chk("fetch_enable", 64'(fetch_enable), 64'(m_en));
        chk("fetch_pc",     64'(fetch_pc),     64'(m_pc));
        chk("queue_count",  64'(queue_count),  64'(m_q.size()));
        chk("out_valid",    64'(out_valid),    64'(exp_v));
        chk("out_pc",       64'(out_pc),       64'(exp_pc));
        chk("out_inst",     64'(out_inst),     64'(exp_inst));

        if (reset) begin
            m_q.delete();
            m_pc = RESET_PC;
            m_en = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc;
            m_en = 1'b0;
        end else begin
            take = byp && out_ready;
            if ((m_q.size() != 0) && out_ready) begin
                dlog.push_back(m_q.pop_front());
            end
            if (mt) begin
                if (take) begin
                    dlog.push_back({mem_pc, mem_inst});
                end else begin
                    m_q.push_back({mem_pc, mem_inst});
                end
                m_pc = m_pc + 32'd4;
            end
            m_en = (m_q.size() < DEPTH);
        end

        if (reset) begin
            st_busy = 1'b0;
        end else if (st_busy) begin
            if (fetch_enable && !mem_choke) begin
                st_busy = 1'b0;
            end else if (st_delay > 0) begin
                st_delay--;
            end
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int maxc;
        int mode;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        out_ready   = 1'b0;
        mem_choke   = 1'b1;
        mem_pc      = 32'h0000_0000;
        mem_inst    = 32'h0000_0000;
        st_busy     = 1'b0;
        st_pc       = 32'h0000_0000;
        st_delay    = 0;
        m_pc        = RESET_PC;
        m_en        = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, pinned by literals.
        chk("rst_fetch_pc",     64'(fetch_pc),     64'h0000_0000_BFC0_0000);
        chk("rst_fetch_enable", 64'(fetch_enable), 64'h0);
        chk("rst_count",        64'(queue_count),  64'h0);
        chk("rst_out_valid",    64'(out_valid),    64'h0);
        chk("rst_out_pc",       64'(out_pc),       64'h0);
        chk("rst_out_inst",     64'(out_inst),     64'h0);

        // Streaming with decode always ready.
        reset     = 1'b0;
        out_ready = 1'b1;
        dlog.delete();
        maxc = 0;
        repeat (30) begin
            cycle();
            if (int'(queue_count) > maxc) maxc = int'(queue_count);
        end
        chk("A_npops_ge3", 64'(dlog.size() >= 3), 64'h1);
        chk("A_pop0", dlog[0], {32'hBFC0_0000, 32'h403F_FFFF});
        chk("A_pop1", dlog[1], {32'hBFC0_0004, 32'h403F_FFFB});
        chk("A_pop2", dlog[2], {32'hBFC0_0008, 32'h403F_FFF7});
        chk("A_max_count_le1", 64'(maxc <= 1), 64'h1);

        // Fill with decode stalled, then drain.
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (20) cycle();
        chk("B_count_full",   64'(queue_count),  64'h4);
        chk("B_enable_low",   64'(fetch_enable), 64'h0);
        chk("B_fetch_pc",     64'(fetch_pc),     64'h0000_0000_BFC0_0010);
        dlog.delete();
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("B_npops_ge5", 64'(dlog.size() >= 5), 64'h1);
        chk("B_pop0_pc", 64'(dlog[0][63:32]), 64'h0000_0000_BFC0_0000);
        chk("B_pop1_pc", 64'(dlog[1][63:32]), 64'h0000_0000_BFC0_0004);
        chk("B_pop2_pc", 64'(dlog[2][63:32]), 64'h0000_0000_BFC0_0008);
        chk("B_pop3_pc", 64'(dlog[3][63:32]), 64'h0000_0000_BFC0_000C);
        chk("B_pop4_pc", 64'(dlog[4][63:32]), 64'h0000_0000_BFC0_0010);

        // Redirect with two entries queued; back-to-back, last target wins.
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (queue_count == 3'd2) break;
            cycle();
        end
        chk("C_count_two", 64'(queue_count), 64'h2);
        redirect    = 1'b1;
        redirect_pc = 32'h9000_0000;
        cycle();
        redirect_pc = 32'h8000_1000;
        cycle();
        redirect = 1'b0;
        chk("C_valid_after", 64'(out_valid),   64'h0);
        chk("C_count_after", 64'(queue_count), 64'h0);
        chk("C_pc_after",    64'(fetch_pc),    64'h0000_0000_8000_1000);
        dlog.delete();
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("C_first_pc", 64'(dlog[0][63:32]), 64'h0000_0000_8000_1000);

        // Randomized traffic with stall bursts, redirects and resets.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) mode = $urandom_range(0, 2);
            reset       = ($urandom_range(0, 199) == 0);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 5) == 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
